ours_input_ppln: RTL and testbench

//  - Two-entry skid buffer for the valid/ready streaming protocol used by ours_* pipeline stages.
//  - Registers both directions: ready_out and valid_out/data_out come only from flops.
//  - Breaks the combinational ready path from downstream to upstream at a stage boundary.
//  - Sits at the receive end of a stage boundary. Pairs with the forward-registered output stage.
//  - Sustains one transfer per cycle. Latency is 1 cycle.

---
 rtl/ours_ppln_pkg.sv | 11 +
 rtl/ours_ppln_dreg.sv | 20 ++
 rtl/ours_input_ppln.sv | 117 +++++++++++
 tb/tb_ours_input_ppln.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ours_ppln_pkg.sv
// Shared types for the ours_* pipeline-stage helpers.
// Provides the skid-buffer state encoding.
package ours_ppln_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } ppln_state_e;

endpackage

// File: rtl/ours_ppln_dreg.sv
// WIDTH-bit load-enable data register with asynchronous active-low reset to zero.
module ours_ppln_dreg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ours_input_ppln.sv
// Two-entry skid buffer at the receive end of a stage boundary; ready and valid come from flops.
// Optional stall counter (stall_clr/stall_cnt) is built when OURS_PPLN_STALL_CNT_EN is defined.
module ours_input_ppln
    import ours_ppln_pkg::*;
#(
    parameter int unsigned WIDTH = 8
`ifdef OURS_PPLN_STALL_CNT_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] data_out
`ifdef OURS_PPLN_STALL_CNT_EN
    ,
    input  logic             stall_clr,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    ppln_state_e      state_q, state_d;
    logic             acc, fire;
    logic             out_en, out_sel_skid, skid_en;
    logic [WIDTH-1:0] out_d, skid_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake outputs are pure decodes of the state flops.
    assign ready_out = (state_q != FULL);
    assign valid_out = (state_q != EMPTY);
    assign acc       = valid_in & ready_out;
    assign fire      = valid_out & ready_in;

    always_comb begin
        state_d      = state_q;
        out_en       = 1'b0;
        out_sel_skid = 1'b0;
        skid_en      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    out_en  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (acc && fire) begin
                    out_en = 1'b1;
                end else if (acc) begin
                    skid_en = 1'b1;
                    state_d = FULL;
                end else if (fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (fire) begin
                    out_en       = 1'b1;
                    out_sel_skid = 1'b1;
                    state_d      = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign out_d = out_sel_skid ? skid_q : data_in;

    ours_ppln_dreg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk  (clk),
        .rstn (rstn),
        .en   (out_en),
        .d    (out_d),
        .q    (data_out)
    );

    ours_ppln_dreg #(
        .WIDTH (WIDTH)
    ) u_skid_reg (
        .clk  (clk),
        .rstn (rstn),
        .en   (skid_en),
        .d    (data_in),
        .q    (skid_q)
    );

`ifdef OURS_PPLN_STALL_CNT_EN
    logic stall;
    assign stall = valid_out & ~ready_in;

    // Clear takes priority over a coincident stall; the count saturates rather than wraps.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (stall && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ours_input_ppln.sv
// Self-checking bench for ours_input_ppln: directed cases plus a randomized scoreboard run.
module tb_ours_input_ppln;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rstn;
    logic             valid_in, ready_in, ready_out, valid_out;
    logic [WIDTH-1:0] data_in, data_out;
`ifdef OURS_PPLN_STALL_CNT_EN
    localparam int unsigned CNT_W = 4;
    logic             stall_clr;
    logic [CNT_W-1:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    ours_input_ppln #(
        .WIDTH (WIDTH)
`ifdef OURS_PPLN_STALL_CNT_EN
        ,
        .CNT_W (CNT_W)
`endif
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_in   (data_in),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .data_out  (data_out)
`ifdef OURS_PPLN_STALL_CNT_EN
        ,
        .stall_clr (stall_clr),
        .stall_cnt (stall_cnt)
`endif
    );

    int               n_checks = 0;
    int               n_pass   = 0;
    logic [WIDTH-1:0] sb_q[$];
    bit               mon_en     = 1'b0;
    bit               acc_seen   = 1'b0;
    bit               stall_prev = 1'b0;
    logic [WIDTH-1:0] data_prev;
    int               ready_low_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshakes are evaluated mid-cycle, where inputs and flop outputs are both settled.
    always @(negedge clk) begin
        if (mon_en && rstn) begin
            check("valid_out_occ", valid_out, sb_q.size() != 0);
            check("ready_out_occ", ready_out, sb_q.size() < 2);
            if (stall_prev) check("stall_hold", data_out, data_prev);
            acc_seen = valid_in & ready_out;
            if (valid_out && ready_in && sb_q.size() != 0) begin
                check("sb_order", data_out, sb_q.pop_front());
            end
            if (acc_seen) sb_q.push_back(data_in);
            stall_prev = valid_out & ~ready_in;
            data_prev  = data_out;
        end else begin
            acc_seen   = 1'b0;
            stall_prev = 1'b0;
        end
    end

    initial begin
        rstn     = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b0;
        data_in  = '0;
`ifdef OURS_PPLN_STALL_CNT_EN
        stall_clr = 1'b0;
`endif
        #2 rstn = 1'b0;
        tick();
        tick();
        check("rst_valid_out", valid_out, 1'b0);
        check("rst_ready_out", ready_out, 1'b1);
        check("rst_data_out", data_out, 8'h00);
        rstn   = 1'b1;
        mon_en = 1'b1;

        // 1. Reset while FULL.
        valid_in = 1'b1; data_in = 8'h11; ready_in = 1'b0;
        tick();
        data_in = 8'h22;
        tick();
        valid_in = 1'b0;
        tick();
        check("t1_full_ready", ready_out, 1'b0);
        check("t1_full_data", data_out, 8'h11);
        #2 rstn = 1'b0;
        #1;
        check("t1_rst_valid", valid_out, 1'b0);
        check("t1_rst_ready", ready_out, 1'b1);
        check("t1_rst_data", data_out, 8'h00);
        sb_q.delete();
        tick();
        rstn = 1'b1;
        valid_in = 1'b1; data_in = 8'h33; ready_in = 1'b1;
        tick();
        valid_in = 1'b0;
        check("t1_first_after_rst", data_out, 8'h33);
        tick();
        tick();

        // 2. Streaming at one beat per cycle.
        ready_in      = 1'b1;
        ready_low_cnt = 0;
        for (int i = 1; i <= 16; i++) begin
            valid_in = 1'b1;
            data_in  = WIDTH'(i);
            tick();
            check("t2_stream", data_out, i);
            if (!ready_out) ready_low_cnt++;
        end
        valid_in = 1'b0;
        tick();
        check("t2_ready_never_low", ready_low_cnt, 0);
        tick();

        // 3. Skid fill.
        valid_in = 1'b1; data_in = 8'hA0; ready_in = 1'b1;
        tick();
        check("t3_a0_out", data_out, 8'hA0);
        ready_in = 1'b0; data_in = 8'hA1;
        tick();
        data_in = 8'hA2;
        check("t3_ready_low", ready_out, 1'b0);
        check("t3_hold_a0", data_out, 8'hA0);
        tick();
        check("t3_still_full", ready_out, 1'b0);
        check("t3_still_a0", data_out, 8'hA0);

        // 4. Drain.
        ready_in = 1'b1;
        tick();
        check("t4_a1_out", data_out, 8'hA1);
        check("t4_ready_back", ready_out, 1'b1);
        tick();
        valid_in = 1'b0;
        check("t4_a2_out", data_out, 8'hA2);
        tick();
        check("t4_empty", valid_out, 1'b0);
        tick();

        // 5. Random traffic; upstream holds a beat until it is accepted.
        for (int c = 0; c < 10000; c++) begin
            if (!valid_in || acc_seen) begin
                valid_in = 1'($urandom_range(0, 1));
                data_in  = WIDTH'($urandom);
            end
            ready_in = ($urandom_range(0, 99) < 60);
            tick();
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        repeat (4) tick();
        check("t5_drained", sb_q.size(), 0);

`ifdef OURS_PPLN_STALL_CNT_EN
        // 6. Stall counter saturation and clear priority.
        valid_in = 1'b1; data_in = 8'h55; ready_in = 1'b1;
        tick();
        valid_in = 1'b0; ready_in = 1'b0; stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        check("t6_clr_wins", stall_cnt, 0);
        repeat (5) tick();
        check("t6_cnt5", stall_cnt, 5);
        repeat (15) tick();
        check("t6_saturated", stall_cnt, 15);
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        check("t6_clr_during_stall", stall_cnt, 0);
        ready_in = 1'b1;
        repeat (3) tick();
`endif

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
